// File: rtl/mtx_sum_reducer.sv
// Adder-tree reducer plus group accumulator for the 16-element product matrix.
// Optional MTX_SUM_SAT_EN clamps the group sum on overflow instead of wrapping.

module mtx_sum_add #(
   parameter int IW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [IW-1:0] a,
   input  logic [IW-1:0] b,
   output logic [IW:0]   s
);
   always_ff @(posedge clk or posedge rst)
      if (rst) s <= '0;
      else     s <= {1'b0, a} + {1'b0, b};
endmodule

module mtx_sum_reducer #(
   parameter int W     = 8,
   parameter int ACC_W = 2*W+8,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic                i_last,
   input  logic                i_clr,
   input  logic [16*2*W-1:0]   i_mtx_m,
   output logic                o_valid,
   output logic [ACC_W-1:0]    o_sum,
   output logic [CNT_W-1:0]    o_cnt,
   output logic                o_ovf
);
   localparam int PW     = 2*W;
   localparam int STAGES = 4;

   logic [15:0][PW-1:0] prod;
   logic [7:0][PW:0]    s1;
   logic [3:0][PW+1:0]  s2;
   logic [1:0][PW+2:0]  s3;
   logic [PW+3:0]       s4;
   logic [STAGES:1]     vld_pipe, lst_pipe;

   assign prod = i_mtx_m;

   for (genvar i = 0; i < 8; i++) begin : g_s1
      mtx_sum_add #(.IW(PW)) u_add (.clk(clk), .rst(rst), .a(prod[2*i]), .b(prod[2*i+1]), .s(s1[i]));
   end
   for (genvar i = 0; i < 4; i++) begin : g_s2
      mtx_sum_add #(.IW(PW+1)) u_add (.clk(clk), .rst(rst), .a(s1[2*i]), .b(s1[2*i+1]), .s(s2[i]));
   end
   for (genvar i = 0; i < 2; i++) begin : g_s3
      mtx_sum_add #(.IW(PW+2)) u_add (.clk(clk), .rst(rst), .a(s2[2*i]), .b(s2[2*i+1]), .s(s3[i]));
   end
   mtx_sum_add #(.IW(PW+3)) u_s4 (.clk(clk), .rst(rst), .a(s3[0]), .b(s3[1]), .s(s4));

   // A clear kills beats already in the tree, but the beat arriving on the same edge survives.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         vld_pipe <= '0;
         lst_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1] & ~{(STAGES-1){i_clr}}, i_valid};
         lst_pipe <= {lst_pipe[STAGES-1:1], i_valid & i_last};
      end

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt_g;
   logic             ovf_g;
   logic [ACC_W:0]   sum_x;
   logic             carry;
   logic [ACC_W-1:0] nxt;
   logic [CNT_W-1:0] cnt_nxt;

   assign sum_x   = {1'b0, acc} + (ACC_W+1)'(s4);
   assign carry   = sum_x[ACC_W];
   assign cnt_nxt = (&cnt_g) ? cnt_g : cnt_g + CNT_W'(1);
`ifdef MTX_SUM_SAT_EN
   assign nxt = carry ? {ACC_W{1'b1}} : sum_x[ACC_W-1:0];
`else
   assign nxt = sum_x[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc     <= '0;
         cnt_g   <= '0;
         ovf_g   <= 1'b0;
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_cnt   <= '0;
         o_ovf   <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (i_clr) begin
            acc   <= '0;
            cnt_g <= '0;
            ovf_g <= 1'b0;
         end else if (vld_pipe[STAGES]) begin
            if (lst_pipe[STAGES]) begin
               o_sum   <= nxt;
               o_cnt   <= cnt_nxt;
               o_ovf   <= ovf_g | carry;
               o_valid <= 1'b1;
               acc     <= '0;
               cnt_g   <= '0;
               ovf_g   <= 1'b0;
            end else begin
               acc   <= nxt;
               cnt_g <= cnt_nxt;
               ovf_g <= ovf_g | carry;
            end
         end
      end
endmodule
